// File: rtl/collapsing_issue_queue.sv
// rtl/collapsing_issue_queue.sv - collapsing in-order-priority issue queue with CDB wakeup
// Optional feature: ISSUEQ_CDB_DISPATCH_BYPASS_EN (same-cycle CDB capture on dispatch).
module collapsing_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OPC_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dispatch_enable,
  input  logic [OPC_W-1:0]           dispatch_opcode,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag,
  input  logic [DATA_W-1:0]          dispatch_rs1_data,
  input  logic [DATA_W-1:0]          dispatch_rs2_data,
  input  logic                       dispatch_rs1_data_val,
  input  logic                       dispatch_rs2_data_val,
  output logic                       issueque_full,
  output logic [$clog2(DEPTH+1)-1:0] issueque_count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [OPC_W-1:0]           issue_opcode,
  output logic [TAG_W-1:0]           issue_rd_tag,
  output logic [DATA_W-1:0]          issue_rs1_data,
  output logic [DATA_W-1:0]          issue_rs2_data
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [OPC_W-1:0]  opc_q      [DEPTH], opc_d      [DEPTH];
  logic [TAG_W-1:0]  rd_tag_q   [DEPTH], rd_tag_d   [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH], rs1_tag_d  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH], rs2_tag_d  [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH], rs1_data_d [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH], rs2_data_d [DEPTH];
  logic [DEPTH-1:0]  rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [CNT_W-1:0]  count_q, count_d, wr_idx;
  logic              sel_found, fire, accept;
  logic [IDX_W-1:0]  sel_idx;

  // Downward scan so the lowest ready index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (vld_q[i] && rs1_val_q[i] && rs2_val_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_valid    = sel_found;
  assign issue_opcode   = sel_found ? opc_q[sel_idx]      : '0;
  assign issue_rd_tag   = sel_found ? rd_tag_q[sel_idx]   : '0;
  assign issue_rs1_data = sel_found ? rs1_data_q[sel_idx] : '0;
  assign issue_rs2_data = sel_found ? rs2_data_q[sel_idx] : '0;

  assign issueque_full  = (count_q == CNT_W'(DEPTH));
  assign issueque_count = count_q;
  assign fire           = sel_found && issue_ready;
  assign accept         = dispatch_enable && !issueque_full;
  assign wr_idx         = count_q - CNT_W'(fire);
  assign count_d        = count_q + CNT_W'(accept) - CNT_W'(fire);

  // Collapse first, then wake the post-shift entry, then place the new dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = (fire && (i >= int'(sel_idx)) && (i < DEPTH-1)) ? i + 1 : i;
      vld_d[i]      = (fire && (i >= int'(sel_idx)) && (i == DEPTH-1)) ? 1'b0 : vld_q[src];
      opc_d[i]      = opc_q[src];
      rd_tag_d[i]   = rd_tag_q[src];
      rs1_tag_d[i]  = rs1_tag_q[src];
      rs2_tag_d[i]  = rs2_tag_q[src];
      rs1_data_d[i] = rs1_data_q[src];
      rs2_data_d[i] = rs2_data_q[src];
      rs1_val_d[i]  = rs1_val_q[src];
      rs2_val_d[i]  = rs2_val_q[src];
      if (vld_d[i] && cdb_valid && !rs1_val_d[i] && (cdb_tag == rs1_tag_d[i])) begin
        rs1_val_d[i]  = 1'b1;
        rs1_data_d[i] = cdb_data;
      end
      if (vld_d[i] && cdb_valid && !rs2_val_d[i] && (cdb_tag == rs2_tag_d[i])) begin
        rs2_val_d[i]  = 1'b1;
        rs2_data_d[i] = cdb_data;
      end
      if (accept && (CNT_W'(i) == wr_idx)) begin
        vld_d[i]      = 1'b1;
        opc_d[i]      = dispatch_opcode;
        rd_tag_d[i]   = dispatch_rd_tag;
        rs1_tag_d[i]  = dispatch_rs1_tag;
        rs2_tag_d[i]  = dispatch_rs2_tag;
        rs1_data_d[i] = dispatch_rs1_data;
        rs2_data_d[i] = dispatch_rs2_data;
        rs1_val_d[i]  = dispatch_rs1_data_val;
        rs2_val_d[i]  = dispatch_rs2_data_val;
`ifdef ISSUEQ_CDB_DISPATCH_BYPASS_EN
        if (cdb_valid && !dispatch_rs1_data_val && (cdb_tag == dispatch_rs1_tag)) begin
          rs1_val_d[i]  = 1'b1;
          rs1_data_d[i] = cdb_data;
        end
        if (cdb_valid && !dispatch_rs2_data_val && (cdb_tag == dispatch_rs2_tag)) begin
          rs2_val_d[i]  = 1'b1;
          rs2_data_d[i] = cdb_data;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through vld_q.
  always_ff @(posedge clk) begin
    rs1_val_q <= rs1_val_d;
    rs2_val_q <= rs2_val_d;
    for (int i = 0; i < DEPTH; i++) begin
      opc_q[i]      <= opc_d[i];
      rd_tag_q[i]   <= rd_tag_d[i];
      rs1_tag_q[i]  <= rs1_tag_d[i];
      rs2_tag_q[i]  <= rs2_tag_d[i];
      rs1_data_q[i] <= rs1_data_d[i];
      rs2_data_q[i] <= rs2_data_d[i];
    end
  end

endmodule

// File: tb/tb_collapsing_issue_queue.sv
// tb/tb_collapsing_issue_queue.sv - directed self-checking bench for collapsing_issue_queue
module tb_collapsing_issue_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_enable;
  logic [3:0]  dispatch_opcode;
  logic [5:0]  dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic        dispatch_rs1_data_val, dispatch_rs2_data_val;
  logic        issueque_full;
  logic [2:0]  issueque_count;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_ready, issue_valid;
  logic [3:0]  issue_opcode;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1_data, issue_rs2_data;

  int tests = 0;
  int fails = 0;

  collapsing_issue_queue dut (
    .clk(clk), .reset(reset), .dispatch_enable(dispatch_enable),
    .dispatch_opcode(dispatch_opcode), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_rs1_data_val(dispatch_rs1_data_val), .dispatch_rs2_data_val(dispatch_rs2_data_val),
    .issueque_full(issueque_full), .issueque_count(issueque_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rd_tag(issue_rd_tag), .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [3:0] opc, input logic [5:0] rd,
                          input logic [5:0] t1, input logic [31:0] d1, input logic v1,
                          input logic [5:0] t2, input logic [31:0] d2, input logic v2);
    dispatch_enable = 1'b1;
    dispatch_opcode = opc;  dispatch_rd_tag = rd;
    dispatch_rs1_tag = t1;  dispatch_rs1_data = d1; dispatch_rs1_data_val = v1;
    dispatch_rs2_tag = t2;  dispatch_rs2_data = d2; dispatch_rs2_data_val = v2;
  endtask

  task automatic disp(input logic [3:0] opc, input logic [5:0] rd,
                      input logic [5:0] t1, input logic [31:0] d1, input logic v1,
                      input logic [5:0] t2, input logic [31:0] d2, input logic v2);
    set_disp(opc, rd, t1, d1, v1, t2, d2, v2);
    step();
    dispatch_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dispatch_enable = 1'b0; issue_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    set_disp(4'h0, 6'd0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    dispatch_enable = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_count", 32'(issueque_count), 32'd0);
    check("rst_full", 32'(issueque_full), 32'd0);
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_opcode", 32'(issue_opcode), 32'd0);

    // Fill with four ready entries; a fifth is dropped.
    for (int k = 1; k <= 4; k++)
      disp(4'(k), 6'(k), 6'd0, 32'h100 + 32'(k), 1'b1, 6'd0, 32'h200 + 32'(k), 1'b1);
    check("fill_count", 32'(issueque_count), 32'd4);
    check("fill_full", 32'(issueque_full), 32'd1);
    check("fill_head_opc", 32'(issue_opcode), 32'd1);
    check("fill_head_rs2", issue_rs2_data, 32'h201);
    disp(4'h5, 6'd5, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b1);
    check("drop5_count", 32'(issueque_count), 32'd4);

    // Full + fire + dispatch: dispatch still dropped.
    issue_ready = 1'b1;
    disp(4'h9, 6'd9, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 1'b1);
    check("fullfire_count", 32'(issueque_count), 32'd3);
    check("fullfire_full", 32'(issueque_full), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      check("drain_opc", 32'(issue_opcode), 32'(k));
      check("drain_rs1", issue_rs1_data, 32'h100 + 32'(k));
      step();
    end
    issue_ready = 1'b0;
    check("drain_count", 32'(issueque_count), 32'd0);
    check("drain_valid", 32'(issue_valid), 32'd0);

    // Three entries waiting on rs1 tags 5,7,9; broadcast tag 7.
    disp(4'hA, 6'd10, 6'd5, 32'h0, 1'b0, 6'd0, 32'h2A, 1'b1);
    disp(4'hB, 6'd11, 6'd7, 32'h0, 1'b0, 6'd0, 32'h2B, 1'b1);
    disp(4'hC, 6'd12, 6'd9, 32'h0, 1'b0, 6'd0, 32'h2C, 1'b1);
    check("pend_count", 32'(issueque_count), 32'd3);
    check("pend_valid", 32'(issue_valid), 32'd0);
    check("pend_rdtag_zero", 32'(issue_rd_tag), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hDEADBEEF;
    step();
    cdb_valid = 1'b0;
    check("wake_valid", 32'(issue_valid), 32'd1);
    check("wake_rs1", issue_rs1_data, 32'hDEADBEEF);
    check("wake_opc", 32'(issue_opcode), 32'hB);
    check("wake_rd", 32'(issue_rd_tag), 32'd11);
    // Hold while not ready.
    step();
    check("hold_opc", 32'(issue_opcode), 32'hB);

    // Issue index 1 with simultaneous dispatch at count 3.
    issue_ready = 1'b1;
    disp(4'hD, 6'd13, 6'd0, 32'h3D, 1'b1, 6'd0, 32'h4D, 1'b1);
    issue_ready = 1'b0;
    check("swap_count", 32'(issueque_count), 32'd3);
    check("swap_opc", 32'(issue_opcode), 32'hD);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h99;
    step();
    cdb_valid = 1'b0;
    check("shifted_opc", 32'(issue_opcode), 32'hC);
    check("shifted_rs1", issue_rs1_data, 32'h99);
    // Fire C while A wakes on tag 5.
    issue_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h55;
    step();
    issue_ready = 1'b0; cdb_valid = 1'b0;
    check("postc_count", 32'(issueque_count), 32'd2);
    check("postc_opc", 32'(issue_opcode), 32'hA);
    check("postc_rs1", issue_rs1_data, 32'h55);
    issue_ready = 1'b1;
    step();
    check("lastd_opc", 32'(issue_opcode), 32'hD);
    step();
    issue_ready = 1'b0;
    check("empty2_count", 32'(issueque_count), 32'd0);

    // Shift and wakeup in the same edge.
    disp(4'h1, 6'd1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h12, 1'b1);
    disp(4'h2, 6'd2, 6'd0, 32'h21, 1'b1, 6'd20, 32'h0, 1'b0);
    issue_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'hCAFE;
    step();
    issue_ready = 1'b0; cdb_valid = 1'b0;
    check("shwake_count", 32'(issueque_count), 32'd1);
    check("shwake_opc", 32'(issue_opcode), 32'h2);
    check("shwake_rs2", issue_rs2_data, 32'hCAFE);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("empty3_count", 32'(issueque_count), 32'd0);

    // Dispatch-cycle CDB match on rs2 tag 12.
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h1234;
    disp(4'h7, 6'd7, 6'd0, 32'h70, 1'b1, 6'd12, 32'h0, 1'b0);
    cdb_valid = 1'b0;
    check("byp_count", 32'(issueque_count), 32'd1);
`ifdef ISSUEQ_CDB_DISPATCH_BYPASS_EN
    check("byp_valid", 32'(issue_valid), 32'd1);
    check("byp_rs2", issue_rs2_data, 32'h1234);
`else
    check("byp_valid", 32'(issue_valid), 32'd0);
    check("byp_rs2", issue_rs2_data, 32'h0);
`endif

    // Reset with three occupied entries and concurrent activity.
    disp(4'h8, 6'd8, 6'd30, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1);
    disp(4'h6, 6'd6, 6'd30, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1);
    check("prerst_count", 32'(issueque_count), 32'd3);
    reset = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd30; cdb_data = 32'h77; issue_ready = 1'b1;
    set_disp(4'h3, 6'd3, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1, 1'b1);
    step();
    reset = 1'b0; cdb_valid = 1'b0; dispatch_enable = 1'b0; issue_ready = 1'b0;
    check("rst2_count", 32'(issueque_count), 32'd0);
    check("rst2_valid", 32'(issue_valid), 32'd0);
    check("rst2_opc", 32'(issue_opcode), 32'd0);
    check("rst2_rd", 32'(issue_rd_tag), 32'd0);
    check("rst2_rs1", issue_rs1_data, 32'd0);
    check("rst2_rs2", issue_rs2_data, 32'd0);
    check("rst2_full", 32'(issueque_full), 32'd0);
    step();
    check("rst2_stay", 32'(issue_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
